// File: rtl/iq_polar_converter_if.sv
// iq_polar_converter_if: sample/result bundle for the CORDIC polar converter.
//   en, iin, qin       : sample strobe and signed I/Q pair (driven by master)
//   mag, phase         : magnitude (>=0) and phase (2^PW counts per turn)
//   valid              : one-clock pulse on a new mag/phase
//   busy               : a sample is in flight
//   overrun            : sticky, a strobe arrived while busy and was dropped
// master = sample source / result sink, slave = converter.
interface iq_polar_converter_if #(
  parameter int unsigned DW = 24,
  parameter int unsigned PW = 32
) ();
  logic                 en;
  logic signed [DW-1:0] iin;
  logic signed [DW-1:0] qin;
  logic signed [DW-1:0] mag;
  logic signed [PW-1:0] phase;
  logic                 valid;
  logic                 busy;
  logic                 overrun;

  modport master (
    output en, iin, qin,
    input  mag, phase, valid, busy, overrun
  );

  modport slave (
    input  en, iin, qin,
    output mag, phase, valid, busy, overrun
  );
endinterface

// File: rtl/iq_polar_converter.sv
// iq_polar_converter: iterative CORDIC vectoring stage, I/Q -> magnitude/phase.
// One sample is accepted in IDLE, rotated ITER times (one micro-rotation per
// clock), then registered out in DONE with a one-clock valid pulse. Latency is
// ITER+1 clocks from the accepting edge; back-to-back period is ITER+2 clocks.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset, clears state and all outputs
//   bus   : iq_polar_converter_if.slave (en/iin/qin in; mag/phase/valid/
//           busy/overrun out)
// Build option:
//   IQ_POLAR_GAIN_COMP_EN : when defined, mag is scaled by 19898/2^15 (~1/1.6468)
//                           to remove the CORDIC gain; otherwise mag = sat(x).
module iq_polar_converter #(
  parameter int unsigned DW   = 24,
  parameter int unsigned PW   = 32,
  parameter int unsigned ITER = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  iq_polar_converter_if.slave  bus
);

  localparam int unsigned KW = (ITER > 1) ? $clog2(ITER) : 1;
  // Two guard bits: room for the exact negation of -2^(DW-1) and for the
  // sqrt(2) * 1.647 growth of x during the rotations.
  localparam int unsigned XW = DW + 2;
  localparam real         Pi = 3.14159265358979323846;

  typedef enum logic [1:0] {StIdle, StRot, StDone} state_e;

  // round(atan(2^-k) * 2^PW / 2pi), evaluated at elaboration only.
  function automatic logic [PW-1:0] atan_entry(input int unsigned k);
    real kr;
    real r;
    kr = k;
    r  = $atan(2.0 ** (-kr)) * (2.0 ** PW) / (2.0 * Pi);
    return PW'(longint'(r));
  endfunction

  logic [PW-1:0] atan_lut [ITER];
  for (genvar g = 0; g < ITER; g++) begin : g_atan
    assign atan_lut[g] = atan_entry(g);
  end

  state_e               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic signed [XW-1:0] x_q, x_d;
  logic signed [XW-1:0] y_q, y_d;
  logic [PW-1:0]        z_q, z_d;
  logic                 zero_q, zero_d;
  logic [DW-1:0]        mag_q, mag_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  logic signed [XW-1:0] iin_ext, qin_ext;
  logic signed [XW-1:0] x_sh, y_sh;

  assign iin_ext = {{2{bus.iin[DW-1]}}, bus.iin};
  assign qin_ext = {{2{bus.qin[DW-1]}}, bus.qin};
  assign x_sh    = x_q >>> k_q;
  assign y_sh    = y_q >>> k_q;

  // Magnitude before saturation.
`ifdef IQ_POLAR_GAIN_COMP_EN
  localparam int unsigned MW = XW + 16;
  localparam logic signed [MW-1:0] GainComp = MW'(19898);
  logic signed [MW-1:0] x_wide, prod, mag_pre;
  assign x_wide  = {{16{x_q[XW-1]}}, x_q};
  assign prod    = x_wide * GainComp;
  assign mag_pre = prod >>> 15;
`else
  localparam int unsigned MW = XW;
  logic signed [MW-1:0] mag_pre;
  assign mag_pre = x_q;
`endif

  localparam logic signed [MW-1:0] MagMax = {{(MW-DW+1){1'b0}}, {(DW-1){1'b1}}};

  logic [DW-1:0] mag_sat;
  always_comb begin
    mag_sat = mag_pre[DW-1:0];
    if (mag_pre[MW-1]) begin
      mag_sat = '0;
    end else if (mag_pre > MagMax) begin
      mag_sat = MagMax[DW-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    zero_d    = zero_q;
    mag_d     = mag_q;
    phase_d   = phase_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;

    if (bus.en && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.en) begin
          // Fold the left half-plane onto the right so CORDIC converges;
          // z starts at pi (== -pi in wrap arithmetic).
          if (iin_ext[XW-1]) begin
            x_d = -iin_ext;
            y_d = -qin_ext;
            z_d = {1'b1, {(PW-1){1'b0}}};
          end else begin
            x_d = iin_ext;
            y_d = qin_ext;
            z_d = '0;
          end
          // (0,0) would otherwise accumulate every table angle into z.
          zero_d  = (bus.iin == '0) && (bus.qin == '0);
          k_d     = '0;
          state_d = StRot;
        end
      end
      StRot: begin
        if (!y_q[XW-1]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_lut[k_q];
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_lut[k_q];
        end
        k_d = k_q + 1'b1;
        if (k_q == KW'(ITER - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        mag_d   = mag_sat;
        phase_d = zero_q ? '0 : z_q;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      k_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      zero_q    <= 1'b0;
      mag_q     <= '0;
      phase_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      zero_q    <= zero_d;
      mag_q     <= mag_d;
      phase_q   <= phase_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.mag     = mag_q;
  assign bus.phase   = phase_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_iq_polar_converter.sv
// Testbench for iq_polar_converter. Expected magnitude/phase come from a
// floating-point model (ideal |I+jQ| times the ITER-stage CORDIC gain, and
// atan2) pushed to a scoreboard queue when a sample is driven and popped when
// valid is seen. Define IQ_POLAR_GAIN_COMP_EN for both DUT and bench together.
module tb_iq_polar_converter;

  localparam int unsigned DW   = 24;
  localparam int unsigned PW   = 32;
  localparam int unsigned ITER = 16;
  localparam int  A      = 4194304;
  localparam int  MagMax = 8388607;
  localparam int  MagTol = 64;       // accumulated shift truncation
  localparam int  PhTol  = 1 << 18;
  localparam int  Lat    = ITER + 1;
  localparam real Pi     = 3.14159265358979323846;

  typedef struct {
    int          mag;
    logic [31:0] phase;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  iq_polar_converter_if #(.DW(DW), .PW(PW)) bus ();

  iq_polar_converter #(.DW(DW), .PW(PW), .ITER(ITER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  real  k_gain;

  function automatic exp_t model(input int i, input int q);
    exp_t   e;
    real    m;
    real    a;
    longint pl;
    m = $sqrt(real'(i) * real'(i) + real'(q) * real'(q)) * k_gain;
`ifdef IQ_POLAR_GAIN_COMP_EN
    m = m * 19898.0 / 32768.0;
`endif
    e.mag = (m >= real'(MagMax)) ? MagMax : int'(m);
    a  = $atan2(real'(q), real'(i));
    pl = longint'(a / (2.0 * Pi) * 4294967296.0);
    e.phase = pl[31:0];
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds en over exactly one edge; returns 1 time unit after that edge.
  task automatic send(input int i, input int q, input bit accept);
    bus.en  = 1'b1;
    bus.iin = DW'(i);
    bus.qin = DW'(q);
    if (accept) sb.push_back(model(i, q));
    step();
    bus.en = 1'b0;
  endtask

  // Waits (bounded) for valid, then pops the scoreboard and scores the result.
  task automatic collect(input string name, input int budget, output int lat);
    exp_t e;
    int   dm;
    int   dp;
    lat = -1;
    for (int c = 0; c <= budget; c++) begin
      if (c > 0) step();
      if (bus.valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    n_vec++;
    if (lat < 0) begin
      n_err++;
      $display("FAIL %s timeout: valid count 0, required 1 within %0d clocks", name, budget);
      return;
    end
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: valid seen with empty scoreboard, required no valid", name);
      return;
    end
    e  = sb.pop_front();
    dm = int'(bus.mag) - e.mag;
    n_vec++;
    if ((e.mag == MagMax) ? (dm != 0) : (dm > MagTol || dm < -MagTol)) begin
      n_err++;
      $display("FAIL %s mag: got %0d, required %0d (+/-%0d)", name, bus.mag, e.mag,
               (e.mag == MagMax) ? 0 : MagTol);
    end
    dp = int'(bus.phase - e.phase);
    n_vec++;
    if (dp > PhTol || dp < -PhTol) begin
      n_err++;
      $display("FAIL %s phase: got 0x%08h, required 0x%08h (+/-0x%0h)", name, bus.phase,
               e.phase, PhTol);
    end
  endtask

  task automatic count_valids(input int cycles, output int cnt);
    cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (bus.valid === 1'b1) cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.iin = '0;
    bus.qin = '0;
    repeat (3) step();
    n_vec += 5;
    if (bus.mag !== '0) begin n_err++; $display("FAIL reset_mag: got %0h, required 0", bus.mag); end
    if (bus.phase !== '0) begin n_err++; $display("FAIL reset_phase: got %0h, required 0", bus.phase); end
    if (bus.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", bus.valid); end
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
    if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b, required 0", bus.overrun); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_latency();
    int lat;
    send(A, 0, 1'b1);
    n_vec++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL lat_busy_set: got %b, required 1", bus.busy); end
    collect("lat_i_axis", 40, lat);
    n_vec += 2;
    if (lat != Lat) begin n_err++; $display("FAIL lat_clocks: got %0d, required %0d", lat, Lat); end
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL lat_busy_clr: got %b, required 0", bus.busy); end
    step();
    n_vec++;
    if (bus.valid !== 1'b0) begin n_err++; $display("FAIL lat_pulse: valid got %b, required 0", bus.valid); end
  endtask

  task automatic test_quadrants();
    int vi[6] = '{0, -A, -A, 0, A, 0};
    int vq[6] = '{A, 0, -A, -A, -A / 2, 0};
    int lat;
    for (int n = 0; n < 6; n++) begin
      send(vi[n], vq[n], 1'b1);
      collect($sformatf("quad_%0d", n), 40, lat);
      step();
    end
  endtask

  task automatic test_saturation();
    int lat;
    send(-8388608, -8388608, 1'b1);
    collect("sat_full_neg", 40, lat);
    n_vec++;
    if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL sat_overrun: got %b, required 0", bus.overrun); end
    step();
  endtask

  task automatic test_back_to_back();
    int lat;
    send(A, 0, 1'b1);
    collect("b2b_first", 40, lat);
    send(0, A, 1'b1);       // en sampled on the edge right after valid
    collect("b2b_second", 40, lat);
    n_vec += 2;
    if (lat != Lat) begin n_err++; $display("FAIL b2b_lat: got %0d, required %0d", lat, Lat); end
    if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b, required 0", bus.overrun); end
    step();
  endtask

  task automatic test_reset_abort();
    int cnt;
    send(A, A, 1'b1);
    repeat (7) step();
    rst_n = 1'b0;
    step();
    sb.delete();
    n_vec += 4;
    if (bus.mag !== '0) begin n_err++; $display("FAIL abort_mag: got %0h, required 0", bus.mag); end
    if (bus.phase !== '0) begin n_err++; $display("FAIL abort_phase: got %0h, required 0", bus.phase); end
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b, required 0", bus.busy); end
    if (bus.valid !== 1'b0) begin n_err++; $display("FAIL abort_valid: got %b, required 0", bus.valid); end
    rst_n = 1'b1;
    count_valids(25, cnt);
    n_vec++;
    if (cnt != 0) begin n_err++; $display("FAIL abort_no_valid: got %0d valids, required 0", cnt); end
  endtask

  task automatic test_overrun();
    int lat;
    int cnt;
    send(A, 0, 1'b1);
    repeat (4) step();
    send(0, A, 1'b0);       // en at t+5 while rotating: dropped
    collect("ovr_first", 40, lat);
    count_valids(25, cnt);
    n_vec += 3;
    if (cnt != 0) begin n_err++; $display("FAIL ovr_extra_valid: got %0d, required 0", cnt); end
    if (bus.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b, required 1", bus.overrun); end
    if (sb.size() != 0) begin n_err++; $display("FAIL ovr_sb_left: got %0d, required 0", sb.size()); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_vec++;
    if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b, required 0", bus.overrun); end
  endtask

  task automatic test_done_overrun();
    int lat;
    int cnt;
    send(A, A, 1'b1);
    repeat (16) step();
    send(A, 0, 1'b0);       // en on the edge that leaves DONE
    collect("done_first", 2, lat);
    count_valids(25, cnt);
    n_vec += 2;
    if (bus.overrun !== 1'b1) begin n_err++; $display("FAIL done_overrun: got %b, required 1", bus.overrun); end
    if (cnt != 0) begin n_err++; $display("FAIL done_extra_valid: got %0d, required 0", cnt); end
  endtask

  initial begin
    k_gain = 1.0;
    for (int k = 0; k < ITER; k++) k_gain = k_gain * $sqrt(1.0 + 2.0 ** (-2.0 * k));
    bus.en  = 1'b0;
    bus.iin = '0;
    bus.qin = '0;
    test_reset();
    test_latency();
    test_quadrants();
    test_saturation();
    test_back_to_back();
    test_reset_abort();
    test_overrun();
    test_done_overrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
